// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: feeds wide operands digit by digit to an external adder and assembles the wide sum
module nibble_serial_adder #(
    parameter int WIDTH      = 4,
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH*NUM_DIGITS-1:0] in_a,
    input  logic [WIDTH*NUM_DIGITS-1:0] in_b,
    output logic [WIDTH-1:0]            add_a,
    output logic [WIDTH-1:0]            add_b,
    input  logic [WIDTH-1:0]            add_sum,
    input  logic                        add_carry,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH*NUM_DIGITS-1:0] out_sum,
    output logic                        out_carry
);
    localparam int N  = WIDTH * NUM_DIGITS;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [IW-1:0]   idx;
    logic            cin;
    logic [WIDTH-1:0] dig_a [NUM_DIGITS];
    logic [WIDTH-1:0] dig_b [NUM_DIGITS];
    logic [WIDTH-1:0] dsum;
    logic             dcarry;
    logic             last;

    genvar i;
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign dig_a[i] = op_a[i*WIDTH +: WIDTH];
        assign dig_b[i] = op_b[i*WIDTH +: WIDTH];
    end

    // The adder has no carry-in, so the previous digit's carry is added here;
    // an all-ones sum plus that carry ripples a carry out as well.
    always_comb begin
        dsum     = add_sum + WIDTH'(cin);
        dcarry   = add_carry | (cin & (&add_sum));
        last     = idx == IW'(NUM_DIGITS - 1);
        in_ready = state == IDLE;
        add_a    = state == RUN ? dig_a[idx] : '0;
        add_b    = state == RUN ? dig_b[idx] : '0;
    end

    // Sequencer: accept operands, step through digits LSB first, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            idx       <= '0;
            cin       <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_a    <= in_a;
                    op_b    <= in_b;
                    idx     <= '0;
                    cin     <= 1'b0;
                    out_sum <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    for (int k = 0; k < NUM_DIGITS; k++)
                        if (idx == IW'(k)) out_sum[k*WIDTH +: WIDTH] <= dsum;
                    cin <= dcarry;
                    idx <= idx + 1'b1;
                    if (last) begin
                        out_carry <= dcarry;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the digit-serial adder with a behavioural 4-bit adder attached
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_sum;
    logic        add_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_carry;

    int vectors = 0;
    int errors  = 0;

    nibble_serial_adder #(.WIDTH(4), .NUM_DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry)
    );

    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (out_sum !== 16'h0000) begin errors++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
        vectors++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got %b want 0", out_carry); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if ({add_a, add_b} !== 8'h00) begin errors++; $display("FAIL reset_add_bus got %h want 00", {add_a, add_b}); end
    endtask

    task automatic test_basic();
        logic [3:0] exp_a [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
        in_a = 16'h1234; in_b = 16'h1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++; if (add_a !== exp_a[k]) begin errors++; $display("FAIL basic_add_a[%0d] got %h want %h", k, add_a, exp_a[k]); end
            vectors++; if (add_b !== 4'h1) begin errors++; $display("FAIL basic_add_b[%0d] got %h want 1", k, add_b); end
            vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d] got %b want 0", k, out_valid); end
            @(negedge clk);
        end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid got %b want 1", out_valid); end
        vectors++; if (out_sum !== 16'h2345) begin errors++; $display("FAIL basic_sum got %h want 2345", out_sum); end
        vectors++; if (out_carry !== 1'b0) begin errors++; $display("FAIL basic_carry got %b want 0", out_carry); end
        vectors++; if ({add_a, add_b} !== 8'h00) begin errors++; $display("FAIL basic_done_bus got %h want 00", {add_a, add_b}); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake valid/ready got %b%b want 01", out_valid, in_ready); end
    endtask

    task automatic test_carry_chain();
        in_a = 16'h00FF; in_b = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL chain_valid got %b want 1", out_valid); end
        vectors++; if (out_sum !== 16'h0100) begin errors++; $display("FAIL chain_sum got %h want 0100", out_sum); end
        vectors++; if (out_carry !== 1'b0) begin errors++; $display("FAIL chain_carry got %b want 0", out_carry); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        in_a = 16'hFFFF; in_b = 16'h0001; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", out_valid); end
        vectors++; if (out_sum !== 16'h0000) begin errors++; $display("FAIL ovf_sum got %h want 0000", out_sum); end
        vectors++; if (out_carry !== 1'b1) begin errors++; $display("FAIL ovf_carry got %b want 1", out_carry); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        in_a = 16'h0001; in_b = 16'h0002; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        in_a = 16'h0027; in_b = 16'h0031; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b want 1", k, out_valid); end
            vectors++; if (out_sum !== 16'h0003) begin errors++; $display("FAIL hold_sum[%0d] got %h want 0003", k, out_sum); end
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %b want 0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle valid/ready got %b%b want 01", out_valid, in_ready); end
        vectors++; if (add_a !== 4'h0) begin errors++; $display("FAIL b2b_idle_add_a got %h want 0", add_a); end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got %b want 0", in_ready); end
        vectors++; if ({add_a, add_b} !== 8'h71) begin errors++; $display("FAIL b2b_digit0 got %h want 71", {add_a, add_b}); end
        repeat (4) @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        vectors++; if (out_sum !== 16'h0058) begin errors++; $display("FAIL b2b_sum got %h want 0058", out_sum); end
        vectors++; if (out_carry !== 1'b0) begin errors++; $display("FAIL b2b_carry got %b want 0", out_carry); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        in_a = 16'h1234; in_b = 16'h1111; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (add_a !== 4'h2) begin errors++; $display("FAIL midrun_idx2_add_a got %h want 2", add_a); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_rst_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_rst_in_ready got %b want 1", in_ready); end
        vectors++; if ({add_a, add_b} !== 8'h00) begin errors++; $display("FAIL midrun_rst_bus got %h want 00", {add_a, add_b}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_a = 16'h0005; in_b = 16'h0003; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
        vectors++; if (out_sum !== 16'h0008) begin errors++; $display("FAIL post_rst_sum got %h want 0008", out_sum); end
        vectors++; if (out_carry !== 1'b0) begin errors++; $display("FAIL post_rst_carry got %b want 0", out_carry); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
